alu_arbiter: RTL and testbench

//  Shares the single registered 8-bit ALU between two requesters (e.g. CPU core, DMA/IO helper).

---
 rtl/alu_arbiter.sv | 120 ++++++++++++
 tb/tb_alu_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered ALU between two requesters.
// Each accepted operation walks IDLE -> ISSUE -> CAPTURE; result returns with a DONE pulse.
module alu_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int OPC_WIDTH  = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  REQ_0,
    input  logic [DATA_WIDTH-1:0] OPA_0,
    input  logic [DATA_WIDTH-1:0] OPB_0,
    input  logic [OPC_WIDTH-1:0]  OPC_0,
    output logic                  ACK_0,
    output logic                  DONE_0,
    input  logic                  REQ_1,
    input  logic [DATA_WIDTH-1:0] OPA_1,
    input  logic [DATA_WIDTH-1:0] OPB_1,
    input  logic [OPC_WIDTH-1:0]  OPC_1,
    output logic                  ACK_1,
    output logic                  DONE_1,
    output logic [DATA_WIDTH-1:0] RESULT,
    output logic                  BUSY,
    output logic [DATA_WIDTH-1:0] ALU_A,
    output logic [DATA_WIDTH-1:0] ALU_B,
    output logic [OPC_WIDTH-1:0]  ALU_OPC,
    input  logic [DATA_WIDTH-1:0] ALU_RESULT
);
    localparam int NREQ = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    logic [NREQ-1:0]                 req;
    logic [NREQ-1:0][DATA_WIDTH-1:0] opa;
    logic [NREQ-1:0][DATA_WIDTH-1:0] opb;
    logic [NREQ-1:0][OPC_WIDTH-1:0]  opc;

    assign req = {REQ_1, REQ_0};
    assign opa = {OPA_1, OPA_0};
    assign opb = {OPB_1, OPB_0};
    assign opc = {OPC_1, OPC_0};

    state_t                state_q;
    logic                  last_q;
    logic                  gnt_q;
    logic                  gnt_d;
    logic [NREQ-1:0]       ack_q;
    logic [NREQ-1:0]       done_q;
    logic                  busy_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic [DATA_WIDTH-1:0] alu_a_q;
    logic [DATA_WIDTH-1:0] alu_b_q;
    logic [OPC_WIDTH-1:0]  alu_opc_q;

    // A lone requester wins outright; on a tie the one that did not finish last wins.
    always_comb begin
        gnt_d = req[1];
        if (&req)
            gnt_d = ~last_q;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            gnt_q     <= 1'b0;
            ack_q     <= '0;
            done_q    <= '0;
            busy_q    <= 1'b0;
            result_q  <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_opc_q <= '0;
        end else begin
            ack_q  <= '0;
            done_q <= '0;
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        gnt_q        <= gnt_d;
                        alu_a_q      <= opa[gnt_d];
                        alu_b_q      <= opb[gnt_d];
                        alu_opc_q    <= opc[gnt_d];
                        ack_q[gnt_d] <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= ISSUE;
                    end
                end
                ISSUE: begin
                    state_q <= CAPTURE;
                end
                CAPTURE: begin
                    // ALU output registered at the end of ISSUE is valid here.
                    result_q      <= ALU_RESULT;
                    done_q[gnt_q] <= 1'b1;
                    last_q        <= gnt_q;
                    busy_q        <= 1'b0;
                    state_q       <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ACK_0   = ack_q[0];
    assign ACK_1   = ack_q[1];
    assign DONE_0  = done_q[0];
    assign DONE_1  = done_q[1];
    assign BUSY    = busy_q;
    assign RESULT  = result_q;
    assign ALU_A   = alu_a_q;
    assign ALU_B   = alu_b_q;
    assign ALU_OPC = alu_opc_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model (grant time, ack/done slots, expected results).
module tb_alu_arbiter;
    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       REQ_0 = 1'b0, REQ_1 = 1'b0;
    logic [7:0] OPA_0 = '0, OPB_0 = '0, OPA_1 = '0, OPB_1 = '0;
    logic [3:0] OPC_0 = '0, OPC_1 = '0;
    logic       ACK_0, ACK_1, DONE_0, DONE_1, BUSY;
    logic [7:0] RESULT, ALU_A, ALU_B, ALU_RESULT;
    logic [3:0] ALU_OPC;

    int n_cmp = 0;
    int n_bad = 0;

    alu_arbiter #(.DATA_WIDTH(8), .OPC_WIDTH(4)) dut (
        .CLK(CLK), .RESET(RESET),
        .REQ_0(REQ_0), .OPA_0(OPA_0), .OPB_0(OPB_0), .OPC_0(OPC_0), .ACK_0(ACK_0), .DONE_0(DONE_0),
        .REQ_1(REQ_1), .OPA_1(OPA_1), .OPB_1(OPB_1), .OPC_1(OPC_1), .ACK_1(ACK_1), .DONE_1(DONE_1),
        .RESULT(RESULT), .BUSY(BUSY), .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_OPC(ALU_OPC),
        .ALU_RESULT(ALU_RESULT)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        logic [15:0] p;
        p = a * b;
        case (op)
            4'h0:    return a + b;
            4'h1:    return a - b;
            4'h2:    return p[7:0];
            4'h3:    return a & b;
            4'h4:    return a | b;
            4'h5:    return a ^ b;
            4'hA:    return (a > b) ? 8'h01 : 8'h00;
            default: return a;
        endcase
    endfunction

    // Registered ALU sharing the arbiter's clock and reset.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) ALU_RESULT <= '0;
        else       ALU_RESULT <= alu_f(ALU_A, ALU_B, ALU_OPC);
    end

    task automatic clk_n(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic do_reset();
        REQ_0 = 0; REQ_1 = 0;
        RESET = 1;
        @(posedge CLK);
        #1;
        RESET = 0;
        clk_n(1);
    endtask

    task automatic test_reset();
        clk_n(2);
        #2;
        RESET = 1;
        #1;
        n_cmp++;
        if ({ACK_1, ACK_0, DONE_1, DONE_0, BUSY, RESULT, ALU_A, ALU_B, ALU_OPC} !== 33'd0) begin
            n_bad++;
            $display("FAIL reset_outs: got %h exp 0", {ACK_1, ACK_0, DONE_1, DONE_0, BUSY, RESULT, ALU_A, ALU_B, ALU_OPC});
        end
        RESET = 0;
        clk_n(2);
        n_cmp++;
        if ({ACK_1, ACK_0, DONE_1, DONE_0, BUSY} !== 5'd0) begin
            n_bad++;
            $display("FAIL reset_idle: got %b exp 00000", {ACK_1, ACK_0, DONE_1, DONE_0, BUSY});
        end
    endtask

    task automatic test_single();
        do_reset();
        REQ_0 = 1; OPA_0 = 8'h05; OPB_0 = 8'h03; OPC_0 = 4'h0;
        clk_n(1);
        n_cmp++;
        if ({ACK_1, ACK_0, BUSY} !== 3'b011) begin
            n_bad++; $display("FAIL t1_ack: got %b exp 011", {ACK_1, ACK_0, BUSY});
        end
        n_cmp++;
        if ({ALU_A, ALU_B, ALU_OPC} !== {8'h05, 8'h03, 4'h0}) begin
            n_bad++; $display("FAIL t1_alu_in: got %h exp 05030", {ALU_A, ALU_B, ALU_OPC});
        end
        REQ_0 = 0;
        clk_n(1);
        n_cmp++;
        if ({ACK_1, ACK_0, DONE_1, DONE_0, BUSY} !== 5'b00001) begin
            n_bad++; $display("FAIL t1_cyc2: got %b exp 00001", {ACK_1, ACK_0, DONE_1, DONE_0, BUSY});
        end
        clk_n(1);
        n_cmp++;
        if ({DONE_1, DONE_0, BUSY, RESULT} !== {3'b010, 8'h08}) begin
            n_bad++; $display("FAIL t1_done: got %b/%h exp 010/08", {DONE_1, DONE_0, BUSY}, RESULT);
        end
        clk_n(1);
        n_cmp++;
        if ({DONE_1, DONE_0, RESULT} !== {2'b00, 8'h08}) begin
            n_bad++; $display("FAIL t1_hold: got %b/%h exp 00/08", {DONE_1, DONE_0}, RESULT);
        end
    endtask

    task automatic test_tie();
        do_reset();
        REQ_0 = 1; OPA_0 = 8'h09; OPB_0 = 8'h04; OPC_0 = 4'h1;
        REQ_1 = 1; OPA_1 = 8'h03; OPB_1 = 8'h04; OPC_1 = 4'h2;
        clk_n(1);
        n_cmp++;
        if ({ACK_1, ACK_0} !== 2'b01) begin
            n_bad++; $display("FAIL t2_ack0: got %b exp 01", {ACK_1, ACK_0});
        end
        REQ_0 = 0;
        clk_n(2);
        n_cmp++;
        if ({ACK_1, ACK_0, DONE_1, DONE_0, RESULT} !== {4'b0001, 8'h05}) begin
            n_bad++; $display("FAIL t2_done0: got %b/%h exp 0001/05", {ACK_1, ACK_0, DONE_1, DONE_0}, RESULT);
        end
        clk_n(1);
        n_cmp++;
        if ({ACK_1, ACK_0, DONE_1, DONE_0} !== 4'b1000) begin
            n_bad++; $display("FAIL t2_ack1: got %b exp 1000", {ACK_1, ACK_0, DONE_1, DONE_0});
        end
        REQ_1 = 0;
        clk_n(2);
        n_cmp++;
        if ({DONE_1, DONE_0, RESULT} !== {2'b10, 8'h0C}) begin
            n_bad++; $display("FAIL t2_done1: got %b/%h exp 10/0c", {DONE_1, DONE_0}, RESULT);
        end
    endtask

    task automatic test_fairness();
        logic [5:0] seq;
        int         cnt;
        int         ovl;
        int         bad_res;
        do_reset();
        OPA_0 = 8'($urandom); OPB_0 = 8'($urandom); OPC_0 = 4'($urandom_range(0, 5));
        OPA_1 = 8'($urandom); OPB_1 = 8'($urandom); OPC_1 = 4'($urandom_range(0, 5));
        REQ_0 = 1; REQ_1 = 1;
        seq = '0; cnt = 0; ovl = 0; bad_res = 0;
        for (int i = 0; i < 18; i++) begin
            clk_n(1);
            if ((ACK_0 && ACK_1) || (DONE_0 && DONE_1) || ((ACK_0 || ACK_1) && (DONE_0 || DONE_1))) ovl++;
            if (ACK_0 || ACK_1) begin
                seq = {seq[4:0], ACK_1};
                cnt++;
            end
            if (DONE_0 && RESULT !== alu_f(OPA_0, OPB_0, OPC_0)) bad_res++;
            if (DONE_1 && RESULT !== alu_f(OPA_1, OPB_1, OPC_1)) bad_res++;
        end
        REQ_0 = 0; REQ_1 = 0;
        n_cmp++;
        if (cnt !== 6) begin
            n_bad++; $display("FAIL t3_count: got %0d exp 6", cnt);
        end
        n_cmp++;
        if (seq !== 6'b010101) begin
            n_bad++; $display("FAIL t3_order: got %b exp 010101", seq);
        end
        n_cmp++;
        if (ovl !== 0) begin
            n_bad++; $display("FAIL t3_overlap: got %0d overlapping cycles exp 0", ovl);
        end
        n_cmp++;
        if (bad_res !== 0) begin
            n_bad++; $display("FAIL t3_result: got %0d wrong results exp 0", bad_res);
        end
        clk_n(3);
    endtask

    task automatic test_wrap();
        logic [27:0] tbl [3];
        tbl[0] = {8'hFF, 8'h02, 4'h0, 8'h01};
        tbl[1] = {8'h80, 8'h7F, 4'hA, 8'h01};
        tbl[2] = {8'h3C, 8'h55, 4'hF, 8'h3C};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            REQ_0 = 1; OPA_0 = tbl[i][27:20]; OPB_0 = tbl[i][19:12]; OPC_0 = tbl[i][11:8];
            clk_n(1);
            REQ_0 = 0;
            clk_n(2);
            n_cmp++;
            if ({DONE_0, RESULT} !== {1'b1, tbl[i][7:0]}) begin
                n_bad++; $display("FAIL t4_op%0d: got %b/%h exp 1/%h", i, DONE_0, RESULT, tbl[i][7:0]);
            end
        end
    endtask

    task automatic test_reset_midop();
        int stray;
        for (int k = 0; k < 2; k++) begin
            do_reset();
            REQ_0 = 1; OPA_0 = 8'h05; OPB_0 = 8'h03; OPC_0 = 4'h0;
            clk_n(1);
            REQ_0 = 0;
            clk_n(3);
            REQ_0 = 1; REQ_1 = 1; OPA_1 = 8'h11; OPB_1 = 8'h22; OPC_1 = 4'h4;
            clk_n(1);
            n_cmp++;
            if ({ACK_1, ACK_0} !== 2'b10) begin
                n_bad++; $display("FAIL t5_pre_ack%0d: got %b exp 10", k, {ACK_1, ACK_0});
            end
            REQ_0 = 0; REQ_1 = 0;
            clk_n(k);
            #2;
            RESET = 1;
            #1;
            n_cmp++;
            if ({ACK_1, ACK_0, DONE_1, DONE_0, BUSY, RESULT, ALU_A, ALU_B, ALU_OPC} !== 33'd0) begin
                n_bad++;
                $display("FAIL t5_zero%0d: got %h exp 0", k, {ACK_1, ACK_0, DONE_1, DONE_0, BUSY, RESULT, ALU_A, ALU_B, ALU_OPC});
            end
            #2;
            RESET = 0;
            stray = 0;
            for (int i = 0; i < 3; i++) begin
                clk_n(1);
                if (DONE_0 || DONE_1 || ACK_0 || ACK_1 || BUSY) stray++;
            end
            n_cmp++;
            if (stray !== 0) begin
                n_bad++; $display("FAIL t5_nodone%0d: got %0d active cycles exp 0", k, stray);
            end
            REQ_0 = 1; REQ_1 = 1;
            clk_n(1);
            n_cmp++;
            if ({ACK_1, ACK_0} !== 2'b01) begin
                n_bad++; $display("FAIL t5_tie%0d: got %b exp 01", k, {ACK_1, ACK_0});
            end
            REQ_0 = 0; REQ_1 = 0;
            clk_n(3);
        end
    endtask

    task automatic test_withdraw();
        int stray;
        do_reset();
        REQ_0 = 1; OPA_0 = 8'h21; OPB_0 = 8'h12; OPC_0 = 4'h5;
        OPA_1 = 8'h44; OPB_1 = 8'h01; OPC_1 = 4'h0;
        clk_n(1);
        REQ_0 = 0;
        clk_n(1);
        REQ_1 = 1;
        clk_n(1);
        REQ_1 = 0;
        n_cmp++;
        if ({DONE_0, BUSY, RESULT} !== {2'b10, 8'h33}) begin
            n_bad++; $display("FAIL t6_done0: got %b/%h exp 10/33", {DONE_0, BUSY}, RESULT);
        end
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            clk_n(1);
            if (ACK_1 || ACK_0 || BUSY) stray++;
        end
        n_cmp++;
        if (stray !== 0) begin
            n_bad++; $display("FAIL t6_withdrawn: got %0d active cycles exp 0", stray);
        end
    endtask

    // Model: a request seen at an edge while the ALU is free is granted; its ack
    // lands one cycle later and its result two cycles after that.
    task automatic test_random(input int ncyc);
        bit         pend [2];
        logic [7:0] ra [2], rb [2];
        logic [3:0] ro [2];
        logic [1:0] eack [16], edone [16];
        logic [7:0] eres [16];
        logic [7:0] hold;
        logic [1:0] acks;
        int         cyc, free_at;
        bit         mlast, w;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            eack[i] = '0; edone[i] = '0; eres[i] = '0;
        end
        for (int x = 0; x < 2; x++) begin
            pend[x] = 0; ra[x] = '0; rb[x] = '0; ro[x] = '0;
        end
        cyc = 0; free_at = 0; mlast = 1; hold = '0;
        for (int n = 0; n < ncyc; n++) begin
            @(posedge CLK);
            if (cyc >= free_at && (REQ_0 || REQ_1)) begin
                w = (REQ_0 && REQ_1) ? !mlast : REQ_1;
                eack[(cyc + 1) % 16][w]  = 1'b1;
                edone[(cyc + 3) % 16][w] = 1'b1;
                eres[(cyc + 3) % 16] = w ? alu_f(OPA_1, OPB_1, OPC_1) : alu_f(OPA_0, OPB_0, OPC_0);
                free_at = cyc + 3;
                mlast = w;
            end
            cyc++;
            #1;
            n_cmp++;
            if ({ACK_1, ACK_0} !== eack[cyc % 16]) begin
                n_bad++; $display("FAIL rnd_ack@%0d: got %b exp %b", cyc, {ACK_1, ACK_0}, eack[cyc % 16]);
            end
            n_cmp++;
            if ({DONE_1, DONE_0} !== edone[cyc % 16]) begin
                n_bad++; $display("FAIL rnd_done@%0d: got %b exp %b", cyc, {DONE_1, DONE_0}, edone[cyc % 16]);
            end
            if (edone[cyc % 16] != 2'b00) hold = eres[cyc % 16];
            n_cmp++;
            if ({BUSY, RESULT} !== {(cyc < free_at), hold}) begin
                n_bad++; $display("FAIL rnd_res@%0d: got %b/%h exp %b/%h", cyc, BUSY, RESULT, (cyc < free_at), hold);
            end
            eack[cyc % 16] = '0; edone[cyc % 16] = '0;
            acks = {ACK_1, ACK_0};
            for (int x = 0; x < 2; x++) begin
                if (acks[x]) pend[x] = 0;
                else if (pend[x] && $urandom_range(0, 9) == 0) pend[x] = 0;
                if (!pend[x] && $urandom_range(0, 2) == 0) begin
                    pend[x] = 1;
                    ra[x] = 8'($urandom); rb[x] = 8'($urandom); ro[x] = 4'($urandom);
                end
            end
            REQ_0 = pend[0]; OPA_0 = ra[0]; OPB_0 = rb[0]; OPC_0 = ro[0];
            REQ_1 = pend[1]; OPA_1 = ra[1]; OPB_1 = rb[1]; OPC_1 = ro[1];
        end
        REQ_0 = 0; REQ_1 = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_fairness();
        test_wrap();
        test_reset_midop();
        test_withdraw();
        test_random(600);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
